// File: rtl/rmt_pkg.sv
// Shared constants and FSM encoding for the rmt stream arbiter and its output slice.
package rmt_pkg;

  localparam int AXIS_DATA_WIDTH  = 512;
  localparam int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8;
  localparam int AXIS_TUSER_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rmt_stream_arb_if.sv
// AXI-Stream bundle used for both arbiter inputs and the merged output.
interface rmt_stream_arb_if
  import rmt_pkg::*;
#(
  parameter int DW = AXIS_DATA_WIDTH,
  parameter int UW = AXIS_TUSER_WIDTH
) ();

  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_out_reg.sv
// One-entry registered AXI-Stream slice; data fields hold when no beat is loaded.
module axis_out_reg
  import rmt_pkg::*;
#(
  parameter int DW = AXIS_DATA_WIDTH,
  parameter int UW = AXIS_TUSER_WIDTH
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic [DW/8-1:0]  in_keep,
  input  logic [UW-1:0]    in_user,
  input  logic             in_last,
  output logic             load,
  rmt_stream_arb_if.master m_axis
);

  // The slice may take a new beat when it is empty or its beat leaves this cycle.
  assign load = ~m_axis.tvalid | m_axis.tready;

  // NOTE: the wide data register is reset too, so the output bus reads all-zero out of reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tuser  <= '0;
      m_axis.tlast  <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      m_axis.tvalid <= in_valid;
      if (in_valid) begin
        m_axis.tdata <= in_data;
        m_axis.tkeep <= in_keep;
        m_axis.tuser <= in_user;
        m_axis.tlast <= in_last;
      end
    end
  end

endmodule

// File: rtl/rmt_stream_arb.sv
// Packet-granular 2:1 AXI-Stream arbiter: port 0 data-plane, port 1 control/config,
// never interleaving beats of different packets, with one registered output stage.
module rmt_stream_arb
  import rmt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = AXIS_TUSER_WIDTH,
  parameter int C_CTRL_PRIO          = 1,
  parameter int C_CNT_WIDTH          = 32
) (
  input  logic                   clk,
  input  logic                   areset,
  rmt_stream_arb_if.slave        s0_axis,
  rmt_stream_arb_if.slave        s1_axis,
  rmt_stream_arb_if.master       m_axis,
  output logic [C_CNT_WIDTH-1:0] pkt_cnt0,
  output logic [C_CNT_WIDTH-1:0] pkt_cnt1
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  arb_state_e      state_q, state_d;
  logic            rr_q, rr_d;
  logic            load;
  logic            acc0, acc1, end0, end1;
  logic            beat_valid, beat_last;
  logic [DW-1:0]   beat_data;
  logic [DW/8-1:0] beat_keep;
  logic [UW-1:0]   beat_user;

  assign s0_axis.tready = (state_q == GRANT0) && load;
  assign s1_axis.tready = (state_q == GRANT1) && load;
  assign acc0 = s0_axis.tvalid & s0_axis.tready;
  assign acc1 = s1_axis.tvalid & s1_axis.tready;
  assign end0 = acc0 & s0_axis.tlast;
  assign end1 = acc1 & s1_axis.tlast;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (s0_axis.tvalid && s1_axis.tvalid)
          state_d = ((C_CTRL_PRIO != 0) || rr_q) ? GRANT1 : GRANT0;
        else if (s0_axis.tvalid)
          state_d = GRANT0;
        else if (s1_axis.tvalid)
          state_d = GRANT1;
      end
      GRANT0: if (end0) begin
        state_d = IDLE;
        rr_d    = 1'b1;
      end
      GRANT1: if (end1) begin
        state_d = IDLE;
        rr_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (end0) pkt_cnt0 <= pkt_cnt0 + C_CNT_WIDTH'(1);
      if (end1) pkt_cnt1 <= pkt_cnt1 + C_CNT_WIDTH'(1);
    end
  end

  // Only the granted port can have an accepted beat, so the mux follows the grant.
  always_comb begin
    beat_valid = acc0 | acc1;
    beat_data  = s0_axis.tdata;
    beat_keep  = s0_axis.tkeep;
    beat_user  = s0_axis.tuser;
    beat_last  = s0_axis.tlast;
    if (state_q == GRANT1) begin
      beat_data = s1_axis.tdata;
      beat_keep = s1_axis.tkeep;
      beat_user = s1_axis.tuser;
      beat_last = s1_axis.tlast;
    end
  end

  axis_out_reg #(.DW(DW), .UW(UW)) u_out_reg (
    .clk      (clk),
    .areset   (areset),
    .in_valid (beat_valid),
    .in_data  (beat_data),
    .in_keep  (beat_keep),
    .in_user  (beat_user),
    .in_last  (beat_last),
    .load     (load),
    .m_axis   (m_axis)
  );

endmodule

// File: tb/tb_rmt_stream_arb.sv
// Directed bench for rmt_stream_arb: one priority instance and one round-robin
// instance with a 2-bit counter, sharing source stimulus.
module tb_rmt_stream_arb;

  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  rmt_stream_arb_if s0_p (), s1_p (), m_p ();
  rmt_stream_arb_if s0_r (), s1_r (), m_r ();
  logic [31:0] cnt_p0, cnt_p1;
  logic [1:0]  cnt_r0, cnt_r1;

  rmt_stream_arb #(.C_CTRL_PRIO(1), .C_CNT_WIDTH(32)) dut_p (
    .clk(clk), .areset(areset), .s0_axis(s0_p), .s1_axis(s1_p), .m_axis(m_p),
    .pkt_cnt0(cnt_p0), .pkt_cnt1(cnt_p1)
  );

  rmt_stream_arb #(.C_CTRL_PRIO(0), .C_CNT_WIDTH(2)) dut_r (
    .clk(clk), .areset(areset), .s0_axis(s0_r), .s1_axis(s1_r), .m_axis(m_r),
    .pkt_cnt0(cnt_r0), .pkt_cnt1(cnt_r1)
  );

  logic         d0_valid = 1'b0, d1_valid = 1'b0, d0_last = 1'b0, d1_last = 1'b0;
  logic [511:0] d0_data = '0, d1_data = '0;
  logic         m_ready = 1'b1;

  assign s0_p.tvalid = d0_valid; assign s0_p.tdata = d0_data; assign s0_p.tlast = d0_last;
  assign s0_p.tkeep = d0_data[63:0]; assign s0_p.tuser = ~d0_data[127:0];
  assign s1_p.tvalid = d1_valid; assign s1_p.tdata = d1_data; assign s1_p.tlast = d1_last;
  assign s1_p.tkeep = d1_data[63:0]; assign s1_p.tuser = ~d1_data[127:0];
  assign s0_r.tvalid = d0_valid; assign s0_r.tdata = d0_data; assign s0_r.tlast = d0_last;
  assign s0_r.tkeep = d0_data[63:0]; assign s0_r.tuser = ~d0_data[127:0];
  assign s1_r.tvalid = d1_valid; assign s1_r.tdata = d1_data; assign s1_r.tlast = d1_last;
  assign s1_r.tkeep = d1_data[63:0]; assign s1_r.tuser = ~d1_data[127:0];
  assign m_p.tready = m_ready;
  assign m_r.tready = m_ready;

  // View of whichever instance the current test targets.
  bit           use_rr = 1'b0;
  logic         a_rdy0, a_rdy1, a_mvalid, a_mlast;
  logic [511:0] a_mdata;
  logic [63:0]  a_mkeep;
  logic [127:0] a_muser;
  logic [31:0]  a_cnt0, a_cnt1;

  always_comb begin
    if (use_rr) begin
      a_rdy0 = s0_r.tready; a_rdy1 = s1_r.tready;
      a_mvalid = m_r.tvalid; a_mlast = m_r.tlast; a_mdata = m_r.tdata;
      a_mkeep = m_r.tkeep; a_muser = m_r.tuser;
      a_cnt0 = {30'd0, cnt_r0}; a_cnt1 = {30'd0, cnt_r1};
    end else begin
      a_rdy0 = s0_p.tready; a_rdy1 = s1_p.tready;
      a_mvalid = m_p.tvalid; a_mlast = m_p.tlast; a_mdata = m_p.tdata;
      a_mkeep = m_p.tkeep; a_muser = m_p.tuser;
      a_cnt0 = cnt_p0; a_cnt1 = cnt_p1;
    end
  end

  beat_t q0[$], q1[$], outq[$];
  bit    pause0 = 1'b0;
  bit    toggle_ready = 1'b0;
  int    n_cmp = 0, n_err = 0;

  function automatic beat_t mk(int port, int pkt, int beat, bit last);
    beat_t b;
    b.data = {16'(port + 1), {29{16'hC3A5}}, 16'(pkt), 16'(beat)};
    b.last = last;
    return b;
  endfunction

  task automatic push_pkt(int port, int pkt, int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (port == 0) q0.push_back(mk(port, pkt, i, i == nbeats - 1));
      else           q1.push_back(mk(port, pkt, i, i == nbeats - 1));
    end
  endtask

  task automatic drive();
    d0_valid = (q0.size() > 0) && !pause0;
    d0_data  = (q0.size() > 0) ? q0[0].data : '0;
    d0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
    d1_valid = (q1.size() > 0);
    d1_data  = (q1.size() > 0) ? q1[0].data : '0;
    d1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  // One clock: drive after negedge, sample at +1, advance, then check 1-cycle latency
  // of any accepted beat and stability of any stalled output beat.
  task automatic step();
    beat_t        acc_beat, ob;
    bit           acc0, acc1, stall;
    logic [511:0] stall_data;
    logic         stall_last;
    drive();
    #1;
    acc0 = d0_valid && a_rdy0;
    acc1 = d1_valid && a_rdy1;
    acc_beat = acc0 ? q0[0] : (acc1 ? q1[0] : '0);
    if (a_mvalid && m_ready) begin
      ob.data = a_mdata;
      ob.last = a_mlast;
      outq.push_back(ob);
      n_cmp++;
      if (a_mkeep !== a_mdata[63:0] || a_muser !== ~a_mdata[127:0]) begin
        n_err++;
        $display("FAIL sideband: got keep=%0h user=%0h for data=%0h", a_mkeep, a_muser, a_mdata);
      end
    end
    stall = a_mvalid && !m_ready;
    stall_data = a_mdata;
    stall_last = a_mlast;
    @(posedge clk);
    @(negedge clk);
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    if (acc0 || acc1) begin
      n_cmp++;
      if (a_mvalid !== 1'b1 || a_mdata !== acc_beat.data || a_mlast !== acc_beat.last) begin
        n_err++;
        $display("FAIL latency: got valid=%b data=%0h last=%b required valid=1 data=%0h last=%b",
                 a_mvalid, a_mdata, a_mlast, acc_beat.data, acc_beat.last);
      end
    end
    if (stall) begin
      n_cmp++;
      if (a_mvalid !== 1'b1 || a_mdata !== stall_data || a_mlast !== stall_last) begin
        n_err++;
        $display("FAIL stall_hold: got valid=%b data=%0h required valid=1 data=%0h",
                 a_mvalid, a_mdata, stall_data);
      end
    end
    if (toggle_ready) m_ready = ~m_ready;
  endtask

  task automatic run_until(int n, int budget);
    int c = 0;
    while (outq.size() < n && c < budget) begin
      step();
      c++;
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (outq.size() != n) begin
      n_err++;
      $display("FAIL beat_count: got %0d beats required %0d", outq.size(), n);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    m_ready = 1'b1;
    toggle_ready = 1'b0;
    pause0 = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    outq.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    use_rr = 1'b0;
    do_reset();
    #1;
    n_cmp++;
    if (a_mvalid !== 1'b0 || a_mdata !== '0 || a_mlast !== 1'b0 || a_rdy0 !== 1'b0 ||
        a_rdy1 !== 1'b0 || a_cnt0 !== 32'd0 || a_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b data=%0h rdy=%b%b cnt=%0d/%0d required all zero",
               a_mvalid, a_mdata, a_rdy0, a_rdy1, a_cnt0, a_cnt1);
    end
    @(negedge clk);
    push_pkt(0, 0, 1);
    push_pkt(0, 1, 4);
    for (int c = 0; c < 20 && outq.size() < 2; c++) step();
    n_cmp++;
    if (a_mvalid !== 1'b1 || a_cnt0 !== 32'd1) begin
      n_err++;
      $display("FAIL pre_reset: got valid=%b cnt0=%0d required valid=1 cnt0=1", a_mvalid, a_cnt0);
    end
    #2 areset = 1'b1;
    #1;
    n_cmp++;
    if (a_mvalid !== 1'b0 || a_rdy0 !== 1'b0 || a_cnt0 !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%b rdy0=%b cnt0=%0d required 0/0/0", a_mvalid, a_rdy0, a_cnt0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (a_mvalid !== 1'b0 || a_rdy0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: got valid=%b rdy0=%b required 0/0", a_mvalid, a_rdy0);
    end
  endtask

  task automatic test_single_pkt();
    beat_t exp[$];
    use_rr = 1'b0;
    do_reset();
    push_pkt(0, 0, 4);
    for (int i = 0; i < 4; i++) exp.push_back(mk(0, 0, i, i == 3));
    run_until(4, 30);
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL single_pkt beat %0d: got %0h/%b required %0h/%b", i, outq[i].data, outq[i].last, exp[i].data, exp[i].last);
      end
    end
    n_cmp++;
    if (a_cnt0 !== 32'd1 || a_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL single_pkt_cnt: got %0d/%0d required 1/0", a_cnt0, a_cnt1);
    end
  endtask

  task automatic test_ctrl_prio();
    beat_t exp[$];
    use_rr = 1'b0;
    do_reset();
    push_pkt(0, 0, 3);
    push_pkt(1, 0, 3);
    for (int i = 0; i < 3; i++) exp.push_back(mk(1, 0, i, i == 2));
    for (int i = 0; i < 3; i++) exp.push_back(mk(0, 0, i, i == 2));
    run_until(6, 40);
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL ctrl_prio beat %0d: got %0h required %0h", i, outq[i].data, exp[i].data);
      end
    end
    n_cmp++;
    if (a_cnt0 !== 32'd1 || a_cnt1 !== 32'd1) begin
      n_err++;
      $display("FAIL ctrl_prio_cnt: got %0d/%0d required 1/1", a_cnt0, a_cnt1);
    end
  endtask

  task automatic test_round_robin();
    beat_t exp[$];
    use_rr = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, k, 2);
      push_pkt(1, k, 2);
      for (int i = 0; i < 2; i++) exp.push_back(mk(0, k, i, i == 1));
      for (int i = 0; i < 2; i++) exp.push_back(mk(1, k, i, i == 1));
    end
    run_until(12, 80);
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL round_robin beat %0d: got %0h required %0h", i, outq[i].data, exp[i].data);
      end
    end
    n_cmp++;
    if (a_cnt0 !== 32'd3 || a_cnt1 !== 32'd3) begin
      n_err++;
      $display("FAIL round_robin_cnt: got %0d/%0d required 3/3", a_cnt0, a_cnt1);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp[$];
    use_rr = 1'b0;
    do_reset();
    toggle_ready = 1'b1;
    push_pkt(0, 5, 4);
    for (int i = 0; i < 4; i++) exp.push_back(mk(0, 5, i, i == 3));
    run_until(4, 40);
    toggle_ready = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL backpressure beat %0d: got %0h/%b required %0h/%b", i, outq[i].data, outq[i].last, exp[i].data, exp[i].last);
      end
    end
  endtask

  task automatic test_hold_grant();
    beat_t exp[$];
    use_rr = 1'b0;
    do_reset();
    push_pkt(0, 7, 4);
    for (int c = 0; c < 20 && outq.size() < 1; c++) step();
    pause0 = 1'b1;
    push_pkt(1, 7, 2);
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (a_rdy1 !== 1'b0) begin
        n_err++;
        $display("FAIL hold_grant cycle %0d: got s1 tready=%b required 0", c, a_rdy1);
      end
    end
    pause0 = 1'b0;
    for (int i = 0; i < 4; i++) exp.push_back(mk(0, 7, i, i == 3));
    for (int i = 0; i < 2; i++) exp.push_back(mk(1, 7, i, i == 1));
    run_until(6, 40);
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL hold_grant beat %0d: got %0h required %0h", i, outq[i].data, exp[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    beat_t exp[$];
    use_rr = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_pkt(0, k, 1);
      exp.push_back(mk(0, k, 0, 1'b1));
    end
    run_until(5, 60);
    for (int i = 0; i < exp.size() && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL back_to_back beat %0d: got %0h/%b required %0h/1", i, outq[i].data, outq[i].last, exp[i].data);
      end
    end
    n_cmp++;
    if (a_cnt0 !== 32'd1 || a_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL cnt_wrap: got %0d/%0d required 1/0", a_cnt0, a_cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_ctrl_prio();
    test_round_robin();
    test_backpressure();
    test_hold_grant();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
